// File: rtl/mac_reducer_pkg.sv
// Shared types and default widths for the mac_reducer stream reduction stage.
package mac_reducer_pkg;

    localparam int unsigned MAC_REDUCER_DATA_WIDTH  = 32;
    localparam int unsigned MAC_REDUCER_ACC_WIDTH   = 48;
    localparam int unsigned MAC_REDUCER_CNT_WIDTH   = 16;
    localparam int unsigned MAC_REDUCER_SHIFT_WIDTH = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } reducer_state_t;

    typedef struct packed {
        logic [MAC_REDUCER_CNT_WIDTH-1:0]   len;
        logic [MAC_REDUCER_CNT_WIDTH-1:0]   ngroups;
        logic [MAC_REDUCER_SHIFT_WIDTH-1:0] shift;
        logic                               sat_en;
        logic                               start;
    } ctrl_reducer_t;

    typedef struct packed {
        logic busy;
        logic done;
        logic ovf;
    } flags_reducer_t;

endpackage

// File: rtl/mac_reducer_sat.sv
// Combinational arithmetic right shift of the accumulator, followed by
// optional signed saturation to the output width.
module mac_reducer_sat
    import mac_reducer_pkg::*;
#(
    parameter int unsigned ACC_WIDTH   = MAC_REDUCER_ACC_WIDTH,
    parameter int unsigned DATA_WIDTH  = MAC_REDUCER_DATA_WIDTH,
    parameter int unsigned SHIFT_WIDTH = MAC_REDUCER_SHIFT_WIDTH
) (
    input  logic [ACC_WIDTH-1:0]   acc_i,
    input  logic [SHIFT_WIDTH-1:0] shift_i,
    input  logic                   sat_en_i,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic                   ovf_o
);

    localparam int unsigned UPPER_WIDTH = ACC_WIDTH - DATA_WIDTH + 1;

    logic signed [ACC_WIDTH-1:0] w_shifted;
    logic [UPPER_WIDTH-1:0]      w_upper;
    logic                        w_fits;

    assign w_shifted = $signed(acc_i) >>> shift_i;

    // Result fits when all bits from the output sign bit upward agree.
    assign w_upper = w_shifted[ACC_WIDTH-1:DATA_WIDTH-1];
    assign w_fits  = (&w_upper) | ~(|w_upper);

    always_comb begin
        data_o = w_shifted[DATA_WIDTH-1:0];
        ovf_o  = 1'b0;
        if (sat_en_i && !w_fits) begin
            ovf_o  = 1'b1;
            data_o = w_shifted[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                            : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/mac_reducer.sv
// Accumulates len signed beats per group into a wide accumulator and emits one
// shifted/saturated result per group, for ngroups groups per job.
module mac_reducer
    import mac_reducer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MAC_REDUCER_DATA_WIDTH,
    parameter int unsigned ACC_WIDTH  = MAC_REDUCER_ACC_WIDTH,
    parameter int unsigned CNT_WIDTH  = MAC_REDUCER_CNT_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  len_i,
    input  logic [CNT_WIDTH-1:0]  ngroups_i,
    input  logic [4:0]            shift_i,
    input  logic                  sat_en_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  ovf_o
);

    localparam int unsigned PKG_CW = MAC_REDUCER_CNT_WIDTH;
    localparam int unsigned EXT_W  = ACC_WIDTH - DATA_WIDTH;

    reducer_state_t        r_state,     w_state_nxt;
    logic [ACC_WIDTH-1:0]  r_acc,       w_acc_nxt;
    logic [CNT_WIDTH-1:0]  r_beat_cnt,  w_beat_cnt_nxt;
    logic [CNT_WIDTH-1:0]  r_grp_cnt,   w_grp_cnt_nxt;
    logic [CNT_WIDTH-1:0]  r_len,       w_len_nxt;
    logic [CNT_WIDTH-1:0]  r_ngroups,   w_ngroups_nxt;
    logic [4:0]            r_shift,     w_shift_nxt;
    logic                  r_sat_en,    w_sat_en_nxt;
    logic                  r_out_valid, w_out_valid_nxt;
    logic [DATA_WIDTH-1:0] r_out_data,  w_out_data_nxt;
    flags_reducer_t        r_flags,     w_flags_nxt;

    ctrl_reducer_t         w_ctrl;
    logic [ACC_WIDTH-1:0]  w_acc_sum;
    logic [DATA_WIDTH-1:0] w_sat_data;
    logic                  w_sat_ovf;
    logic                  w_in_hs;
    logic                  w_out_hs;
    logic                  w_last_beat;
    logic                  w_last_grp;

    assign w_ctrl.len     = PKG_CW'(len_i);
    assign w_ctrl.ngroups = PKG_CW'(ngroups_i);
    assign w_ctrl.shift   = shift_i;
    assign w_ctrl.sat_en  = sat_en_i;
    assign w_ctrl.start   = start_i;

    assign in_ready_o  = (r_state == ST_ACC);
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign busy_o      = r_flags.busy;
    assign done_o      = r_flags.done;
    assign ovf_o       = r_flags.ovf;

    assign w_in_hs     = in_valid_i & in_ready_o;
    assign w_out_hs    = r_out_valid & out_ready_i;
    assign w_acc_sum   = r_acc + {{EXT_W{in_data_i[DATA_WIDTH-1]}}, in_data_i};
    assign w_last_beat = (r_beat_cnt == r_len - CNT_WIDTH'(1));
    assign w_last_grp  = (r_grp_cnt == r_ngroups - CNT_WIDTH'(1));

    // The emitted value includes the beat being accepted this cycle.
    mac_reducer_sat #(
        .ACC_WIDTH   (ACC_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .SHIFT_WIDTH (5)
    ) u_sat (
        .acc_i    (w_acc_sum),
        .shift_i  (r_shift),
        .sat_en_i (r_sat_en),
        .data_o   (w_sat_data),
        .ovf_o    (w_sat_ovf)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_acc_nxt        = r_acc;
        w_beat_cnt_nxt   = r_beat_cnt;
        w_grp_cnt_nxt    = r_grp_cnt;
        w_len_nxt        = r_len;
        w_ngroups_nxt    = r_ngroups;
        w_shift_nxt      = r_shift;
        w_sat_en_nxt     = r_sat_en;
        w_out_valid_nxt  = r_out_valid;
        w_out_data_nxt   = r_out_data;
        w_flags_nxt      = r_flags;
        w_flags_nxt.done = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_ctrl.start) begin
                    w_flags_nxt.ovf = 1'b0;
                    if (w_ctrl.len != '0 && w_ctrl.ngroups != '0) begin
                        w_len_nxt      = CNT_WIDTH'(w_ctrl.len);
                        w_ngroups_nxt  = CNT_WIDTH'(w_ctrl.ngroups);
                        w_shift_nxt    = w_ctrl.shift;
                        w_sat_en_nxt   = w_ctrl.sat_en;
                        w_acc_nxt      = '0;
                        w_beat_cnt_nxt = '0;
                        w_grp_cnt_nxt  = '0;
                        w_state_nxt    = ST_ACC;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_ACC: begin
                if (w_in_hs) begin
                    w_acc_nxt      = w_acc_sum;
                    w_beat_cnt_nxt = r_beat_cnt + CNT_WIDTH'(1);
                    if (w_last_beat) begin
                        w_out_data_nxt  = w_sat_data;
                        w_out_valid_nxt = 1'b1;
                        w_flags_nxt.ovf = r_flags.ovf | w_sat_ovf;
                        w_state_nxt     = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (w_out_hs) begin
                    w_out_valid_nxt = 1'b0;
                    w_grp_cnt_nxt   = r_grp_cnt + CNT_WIDTH'(1);
                    if (w_last_grp) begin
                        w_flags_nxt.done = 1'b1;
                        w_state_nxt      = ST_DONE;
                    end else begin
                        w_acc_nxt      = '0;
                        w_beat_cnt_nxt = '0;
                        w_state_nxt    = ST_ACC;
                    end
                end
            end
            ST_DONE: begin
                // Pulse here only if the pulse was not already raised on entry
                // (zero-length jobs enter DONE without one).
                w_flags_nxt.done = ~r_flags.done;
                w_state_nxt      = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_flags_nxt.busy = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_beat_cnt  <= '0;
            r_grp_cnt   <= '0;
            r_len       <= '0;
            r_ngroups   <= '0;
            r_shift     <= '0;
            r_sat_en    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_flags     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_grp_cnt   <= w_grp_cnt_nxt;
            r_len       <= w_len_nxt;
            r_ngroups   <= w_ngroups_nxt;
            r_shift     <= w_shift_nxt;
            r_sat_en    <= w_sat_en_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_flags     <= w_flags_nxt;
        end
    end

endmodule
